force_stim_seq: RTL and testbench
=================================

// Module: force_stim_seq
// PURPOSE
//   Stimulus sequencer: the driving end of the combinational-observer checks.
//   Stores a short pattern of input values, then plays it onto a driven net
//   one value per handshake, with a programmable gap between values.
//   Sits between the bench control logic and the unit under observation, which
//   samples stim_out whenever stim_valid && stim_ready.
// PARAMETERS
//   WIDTH  1  width of each stimulus value
//   DEPTH  8  pattern entries, power of 2, >= 2
//   HOLD   1  idle cycles between accepted beats, >= 1
// PORTS
//   clk         in   1             single clock, rising edge
//   rst         in   1             asynchronous reset, active-high
//   load_valid  in   1             pattern write request
//   load_data   in   WIDTH         value to append to pattern
//   load_ready  out  1             pattern write accepted this cycle
//   clear       in   1             empty the pattern (IDLE only)
//   start       in   1             begin playback (IDLE only)
//   stim_out    out  WIDTH         driven value; holds last accepted beat
//   stim_valid  out  1             new beat offered on stim_out
//   stim_ready  in   1             consumer accepts beat
//   busy        out  1             state != IDLE
//   done        out  1             one-cycle pulse at end of playback
//   count       out  $clog2(DEPTH)+1  entries stored
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, count=0, pointers=0, stim_out='0,
//     stim_valid=0, done=0, busy=0; buffer contents undefined.
//   States: IDLE, PLAY, GAP, DONE.
//   IDLE: load_ready = (count != DEPTH). load_valid&&load_ready writes buf[count],
//     count+1. Full: write ignored, count unchanged. clear: count=0; clear wins
//     over same-cycle load. start: count!=0 -> PLAY, rd_ptr=0; count==0 -> DONE.
//     Same-cycle load+start: entry stored and included in playback.
//   PLAY: stim_valid=1, stim_out=buf[rd_ptr] (registered, valid 1 cycle after
//     entering). Values stable while stim_ready=0. On handshake:
//     rd_ptr==count-1 -> DONE, else rd_ptr+1, hold_cnt=HOLD -> GAP.
//   GAP: stim_valid=0, stim_out keeps last accepted value; hold_cnt decrements;
//     at 1 -> PLAY. Latency accept-to-next-valid = HOLD+1 cycles.
//   DONE: done=1 exactly one cycle, stim_valid=0, -> IDLE. Pattern retained;
//     next start replays it.
//   start/clear/load ignored outside IDLE (load_ready=0 when busy).
//   stim_out never returns to 0 after playback: last value persists, as a
//     forced net does, until reset or next beat.
//   Reset mid-PLAY/GAP: outputs to reset values at once, pattern discarded.
//   No arithmetic wrap: rd_ptr bounded by count-1; count saturates at DEPTH.
// STRUCTURE
//   stim_pkg: typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP, ST_DONE}
//     stim_state_t; function/constant for pointer width.
//   Sub-module stim_pattern_mem: DEPTH x WIDTH regfile, 1 write port,
//     1 async read port; no reset on storage.
//   Top: FSM, count/rd_ptr/hold_cnt registers, registered stim_out/valid/done.
// TESTING
//   1 rst pulse mid-cycle -> stim_out=0, stim_valid=0, busy=0, count=0, load_ready=1.
//   2 Load 1,0,1; start; stim_ready=1, HOLD=1 -> beats 1,0,1 accepted 2 cycles
//     apart, done pulses 1 cycle after third accept, stim_out stays 1 after.
//   3 Hold stim_ready=0 for 3 cycles during PLAY -> stim_valid=1, stim_out
//     unchanged all 3 cycles; beat accepted once when ready rises.
//   4 DEPTH=8: 9 loads -> 9th sees load_ready=0, count=8; playback emits 8 beats.
//   5 start with count=0 -> done pulse next cycle, stim_valid never asserted;
//     start during PLAY -> ignored, sequence unaffected.
//   6 Assert rst after 2nd beat of 4 -> outputs reset immediately; subsequent
//     start without reload -> done pulse, no beats.

Source files
------------

// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pkg
//  Description : Shared state encoding and width helpers for the stimulus
//                sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } stim_state_t;

    // Address width for a pattern of 'depth' entries (never below one bit).
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Width of a down-counter that must hold the value 'n'.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage : stim_pkg
`default_nettype wire

// File: rtl/stim_pattern_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stim_pattern_mem
//  Description : DEPTH x WIDTH pattern register file, one synchronous write
//                port and one asynchronous read port; storage is not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module stim_pattern_mem #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : stim_pattern_mem
`default_nettype wire

// File: rtl/force_stim_seq.sv
`default_nettype none
// ============================================================================
//  Module      : force_stim_seq
//  Description : Stimulus sequencer; stores a short pattern and plays it onto
//                stim_out one value per handshake with a programmable gap.
//  Revision    : 1.0  initial release
// ============================================================================
module force_stim_seq
    import stim_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int HOLD  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid,
    input  logic [WIDTH-1:0]             load_data,
    output logic                         load_ready,
    input  logic                         clear,
    input  logic                         start,
    output logic [WIDTH-1:0]             stim_out,
    output logic                         stim_valid,
    input  logic                         stim_ready,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = cnt_width(HOLD);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD);

    stim_state_t      state;
    logic [PW-1:0]    rd_ptr;
    logic [HW-1:0]    hold_cnt;
    logic [WIDTH-1:0] rd_data;
    logic             in_idle;
    logic             wr_en;
    logic             last_beat;
    logic [CW-1:0]    next_count;

    assign in_idle    = (state == ST_IDLE);
    assign busy       = !in_idle;
    assign load_ready = in_idle && (count != FULL_COUNT);

    // A clear in the same cycle as a load discards the load.
    assign wr_en      = load_valid && load_ready && !clear;
    assign last_beat  = (({1'b0, rd_ptr} + CW'(1)) == count);

    always_comb begin
        next_count = count;
        if (clear) begin
            next_count = '0;
        end else if (wr_en) begin
            next_count = count + CW'(1);
        end
    end

    stim_pattern_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (count[PW-1:0]),
        .wdata (load_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            rd_ptr     <= '0;
            hold_cnt   <= '0;
            stim_out   <= '0;
            stim_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    count <= next_count;
                    // Start sees the post-load/post-clear count, so a same-cycle
                    // load is part of the playback.
                    if (start) begin
                        rd_ptr <= '0;
                        if (next_count != '0) begin
                            state <= ST_PLAY;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_PLAY: begin
                    if (!stim_valid) begin
                        stim_valid <= 1'b1;
                        stim_out   <= rd_data;
                    end else if (stim_ready) begin
                        stim_valid <= 1'b0;
                        if (last_beat) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            rd_ptr   <= rd_ptr + PW'(1);
                            hold_cnt <= HOLD_LOAD;
                            state    <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    // Re-offer on the exit edge so beats are HOLD+1 cycles apart.
                    if (hold_cnt <= HW'(1)) begin
                        state      <= ST_PLAY;
                        stim_valid <= 1'b1;
                        stim_out   <= rd_data;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : force_stim_seq
`default_nettype wire

// File: tb/tb_force_stim_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_force_stim_seq
//  Description : Directed self-checking bench for force_stim_seq with a beat
//                scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_force_stim_seq;

    localparam int WIDTH = 1;
    localparam int DEPTH = 8;
    localparam int HOLD  = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             clear = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] stim_out;
    logic             stim_valid;
    logic             stim_ready = 1'b0;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WIDTH-1:0] pat[$];
    logic [WIDTH-1:0] exp_q[$];
    int               acc_cyc[$];

    force_stim_seq #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .clear      (clear),
        .start      (start),
        .stim_out   (stim_out),
        .stim_valid (stim_valid),
        .stim_ready (stim_ready),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL timeout global bound reached");
        $fatal(1, "global timeout");
    end

    // Values at the negedge are what the next rising edge will sample.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (!rst && stim_valid === 1'b1 && stim_ready === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL beat_unexpected obs=%0h exp=none", stim_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (stim_out === e)
                else begin
                    errors++;
                    $error("FAIL beat_value obs=%0h exp=%0h", stim_out, e);
                end
            end
            acc_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] d);
        chk("load_ready", {31'd0, load_ready}, {31'd0, pat.size() < DEPTH});
        load_valid = 1'b1;
        load_data  = d;
        step();
        load_valid = 1'b0;
        if (pat.size() < DEPTH) pat.push_back(d);
    endtask

    task automatic queue_pattern();
        foreach (pat[i]) exp_q.push_back(pat[i]);
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        dcyc = cyc;
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic play(output int dcyc);
        queue_pattern();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(200, dcyc);
    endtask

    initial begin
        int dcyc;
        int n;
        logic [8:0] vec;

        // 1: asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1;
        chk("rst_stim_out", {31'd0, stim_out}, 32'd0);
        chk("rst_valid", {31'd0, stim_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step();

        // 2: three beats, HOLD=1, consumer always ready
        load(1'b1); load(1'b0); load(1'b1);
        chk("count3", {28'd0, count}, 32'd3);
        stim_ready = 1'b1;
        acc_cyc.delete();
        play(dcyc);
        chk("beats3", acc_cyc.size(), 32'd3);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk("beat_spacing", acc_cyc[i] - acc_cyc[i-1], HOLD + 1);
        if (acc_cyc.size() == 3) chk("done_after_last", dcyc - acc_cyc[2], 32'd1);
        chk("q_empty2", exp_q.size(), 32'd0);
        chk("stim_valid_in_done", {31'd0, stim_valid}, 32'd0);
        step();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        repeat (3) step();
        chk("stim_out_persists", {31'd0, stim_out}, 32'd1);
        chk("count_retained", {28'd0, count}, 32'd3);

        // 3: stall the consumer during PLAY
        stim_ready = 1'b0;
        acc_cyc.delete();
        queue_pattern();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'd0, stim_valid}, 32'd1);
            chk("stall_out", {31'd0, stim_out}, {31'd0, pat[0]});
            step();
        end
        chk("stall_no_accept", acc_cyc.size(), 32'd0);
        stim_ready = 1'b1;
        wait_done(200, dcyc);
        chk("beats_after_stall", acc_cyc.size(), 32'd3);
        chk("q_empty3", exp_q.size(), 32'd0);
        step();

        // clear beats a same-cycle load
        clear = 1'b1; load_valid = 1'b1; load_data = 1'b1;
        step();
        clear = 1'b0; load_valid = 1'b0;
        pat.delete();
        chk("clear_wins", {28'd0, count}, 32'd0);

        // 4: overfill, then playback with a stray start mid-sequence
        vec = 9'b1_0110_1001;
        for (int i = 0; i < 9; i++) load(vec[i]);
        chk("count_full", {28'd0, count}, DEPTH);
        chk("load_ready_full", {31'd0, load_ready}, 32'd0);
        acc_cyc.delete();
        queue_pattern();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("load_ready_busy", {31'd0, load_ready}, 32'd0);
        wait_done(200, dcyc);
        chk("beats8", acc_cyc.size(), DEPTH);
        chk("q_empty4", exp_q.size(), 32'd0);
        step();
        chk("idle_after_stray_start", {31'd0, busy}, 32'd0);

        // 5: start with an empty pattern
        clear = 1'b1;
        step();
        clear = 1'b0;
        pat.delete();
        acc_cyc.delete();
        play(dcyc);
        chk("empty_valid", {31'd0, stim_valid}, 32'd0);
        step();
        chk("empty_done_pulse", {31'd0, done}, 32'd0);
        chk("empty_no_beats", acc_cyc.size(), 32'd0);

        // same-cycle load and start: entry is played
        pat.push_back(1'b1);
        queue_pattern();
        load_valid = 1'b1; load_data = 1'b1; start = 1'b1;
        step();
        load_valid = 1'b0; start = 1'b0;
        wait_done(200, dcyc);
        chk("load_start_beats", acc_cyc.size(), 32'd1);
        step();

        // 6: reset after the 2nd of 4 beats
        clear = 1'b1;
        step();
        clear = 1'b0;
        pat.delete();
        load(1'b1); load(1'b1); load(1'b0); load(1'b1);
        acc_cyc.delete();
        queue_pattern();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (acc_cyc.size() < 2 && n < 100) begin
            step();
            n++;
        end
        chk("two_beats_seen", acc_cyc.size(), 32'd2);
        step();
        #2 rst = 1'b1;
        #1;
        chk("midrst_stim_out", {31'd0, stim_out}, 32'd0);
        chk("midrst_valid", {31'd0, stim_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {28'd0, count}, 32'd0);
        exp_q.delete();
        pat.delete();
        @(negedge clk);
        rst = 1'b0;
        step();
        acc_cyc.delete();
        play(dcyc);
        step();
        chk("postrst_no_beats", acc_cyc.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_force_stim_seq
`default_nettype wire
